// File: rtl/io_spi_mgmt_responder_pkg.sv
// Encodings shared between the SPI management controller and the IO responder.
package io_spi_mgmt_responder_pkg;

    localparam logic [1:0] MODE_MGMT  = 2'b00;
    localparam logic [1:0] MODE_IN    = 2'b01;
    localparam logic [1:0] MODE_OUT   = 2'b10;
    localparam logic [1:0] MODE_FAULT = 2'b11;

    localparam logic [7:0] CMD_NOP       = 8'h00;
    localparam logic [7:0] CMD_GET_MODE  = 8'h01;
    localparam logic [7:0] CMD_SET_IN    = 8'h02;
    localparam logic [7:0] CMD_SET_OUT   = 8'h03;
    localparam logic [7:0] CMD_SET_LED   = 8'h04;
    localparam logic [7:0] CMD_SET_FAULT = 8'h0F;

    localparam logic [7:0] RSP_ACK       = 8'h5A;
    localparam logic [7:0] RSP_NAK       = 8'hEE;
    localparam logic [3:0] STATUS_NIBBLE = 4'hA;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_TAIL = 2'd3;

    function automatic logic [7:0] status_byte(input logic [1:0] mode);
        return {STATUS_NIBBLE, 2'b00, mode};
    endfunction

    // FAULT is sticky, so mode-changing commands are refused while in it.
    function automatic logic [7:0] cmd_response(input logic [7:0] cmd, input logic [1:0] mode);
        logic [7:0] rsp;
        case (cmd)
            CMD_NOP:                  rsp = 8'h00;
            CMD_GET_MODE:             rsp = {6'b0, mode};
            CMD_SET_IN, CMD_SET_OUT:  rsp = (mode == MODE_FAULT) ? RSP_NAK : RSP_ACK;
            CMD_SET_LED, CMD_SET_FAULT: rsp = RSP_ACK;
            default:                  rsp = RSP_NAK;
        endcase
        return rsp;
    endfunction

endpackage

// File: rtl/io_spi_sync_edge.sv
// Two-flop synchronizers for the SPI pins plus edge detection on sclk and n_ss.
module io_spi_sync_edge (
    input  logic clk_in,
    input  logic n_reset,
    input  logic sclk_i,
    input  logic mosi_i,
    input  logic n_ss_i,
    output logic mosi_s_o,
    output logic sclk_rise_o,
    output logic sclk_fall_o,
    output logic ss_fall_o,
    output logic ss_rise_o
);
    // bit 0 = sclk, bit 1 = mosi, bit 2 = n_ss
    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic [1:0] prev_q;

    // Clearing n_ss to 0 means a frame still selected at reset release shows
    // no falling edge; the responder waits for a fresh select.
    always_ff @(negedge clk_in) begin
        if (!n_reset) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            prev_q  <= 2'b00;
        end else begin
            sync1_q <= {n_ss_i, mosi_i, sclk_i};
            sync2_q <= sync1_q;
            prev_q  <= {sync2_q[2], sync2_q[0]};
        end
    end

    assign mosi_s_o    = sync2_q[1];
    assign sclk_rise_o =  sync2_q[0] & ~prev_q[0];
    assign sclk_fall_o = ~sync2_q[0] &  prev_q[0];
    assign ss_fall_o   = ~sync2_q[2] &  prev_q[1];
    assign ss_rise_o   =  sync2_q[2] & ~prev_q[1];

endmodule

// File: rtl/io_spi_mgmt_responder.sv
// SPI mode-0 responder: status byte, command byte, data byte, then zero tail.
// cmd_valid is a one-cycle strobe with cmd_byte valid in the same cycle; no ready.
module io_spi_mgmt_responder
    import io_spi_mgmt_responder_pkg::*;
(
    input  logic       clk_in,
    input  logic       n_reset,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    input  logic       spi_n_ss,
    output logic       spi_miso,
    output logic [1:0] io_mode,
    output logic       status_grn,
    output logic       status_red,
    output logic       cmd_valid,
    output logic [7:0] cmd_byte,
    output logic [1:0] dbg_state_o
);
    logic mosi_s, sclk_rise, sclk_fall, ss_fall, ss_rise;

    io_spi_sync_edge u_sync (
        .clk_in      (clk_in),
        .n_reset     (n_reset),
        .sclk_i      (spi_sclk),
        .mosi_i      (spi_mosi),
        .n_ss_i      (spi_n_ss),
        .mosi_s_o    (mosi_s),
        .sclk_rise_o (sclk_rise),
        .sclk_fall_o (sclk_fall),
        .ss_fall_o   (ss_fall),
        .ss_rise_o   (ss_rise)
    );

    logic [1:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] tx_q, tx_d;
    logic [6:0] rx_q, rx_d;
    logic [7:0] cmd_q, cmd_d;
    logic [1:0] io_mode_q, io_mode_d;
    logic       grn_q, grn_d, red_q, red_d;
    logic       miso_q, miso_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic [7:0] cmd_byte_q, cmd_byte_d;
    logic [7:0] rx_byte;

    assign rx_byte = {rx_q, mosi_s};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        cmd_d       = cmd_q;
        io_mode_d   = io_mode_q;
        grn_d       = grn_q;
        red_d       = red_q;
        cmd_valid_d = 1'b0;
        cmd_byte_d  = cmd_byte_q;

        if (ss_rise) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            tx_d      = 8'h00;
        end else if (ss_fall && state_q == ST_IDLE) begin
            state_d   = ST_CMD;
            bit_cnt_d = 3'd0;
            tx_d      = status_byte(io_mode_q);
        end else if (state_q != ST_IDLE) begin
            if (sclk_rise) begin
                rx_d      = rx_byte[6:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
                // Next byte is loaded on the 8th rising edge so its MSB is out
                // before the following rising edge; the falling edge in between
                // (bit_cnt 0) must not shift.
                if (bit_cnt_q == 3'd7) begin
                    if (state_q == ST_CMD) begin
                        cmd_d   = rx_byte;
                        tx_d    = cmd_response(rx_byte, io_mode_q);
                        state_d = ST_DATA;
                    end else if (state_q == ST_DATA) begin
                        state_d     = ST_TAIL;
                        tx_d        = 8'h00;
                        cmd_valid_d = 1'b1;
                        cmd_byte_d  = cmd_q;
                        case (cmd_q)
                            CMD_SET_IN:  if (io_mode_q != MODE_FAULT) io_mode_d = MODE_IN;
                            CMD_SET_OUT: if (io_mode_q != MODE_FAULT) io_mode_d = MODE_OUT;
                            CMD_SET_LED: begin
                                grn_d = rx_byte[0];
                                red_d = rx_byte[1];
                            end
                            CMD_SET_FAULT: begin
                                io_mode_d = MODE_FAULT;
                                grn_d     = 1'b0;
                                red_d     = 1'b1;
                            end
                            default: ;
                        endcase
                    end else begin
                        tx_d = 8'h00;
                    end
                end
            end else if (sclk_fall && bit_cnt_q != 3'd0) begin
                tx_d = {tx_q[6:0], 1'b0};
            end
        end

        miso_d = (state_d != ST_IDLE) ? tx_d[7] : 1'b0;
    end

    always_ff @(negedge clk_in) begin
        if (!n_reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            tx_q        <= 8'h00;
            rx_q        <= 7'h00;
            cmd_q       <= 8'h00;
            io_mode_q   <= MODE_OUT;
            grn_q       <= 1'b0;
            red_q       <= 1'b1;
            miso_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_byte_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            cmd_q       <= cmd_d;
            io_mode_q   <= io_mode_d;
            grn_q       <= grn_d;
            red_q       <= red_d;
            miso_q      <= miso_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_byte_q  <= cmd_byte_d;
        end
    end

    assign spi_miso    = miso_q;
    assign io_mode     = io_mode_q;
    assign status_grn  = grn_q;
    assign status_red  = red_q;
    assign cmd_valid   = cmd_valid_q;
    assign cmd_byte    = cmd_byte_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_io_spi_mgmt_responder.sv
// Bench for io_spi_mgmt_responder: an SPI mode-0 master drives frames, MISO bytes
// and cmd_valid strobes are checked against expected queues.
module tb_io_spi_mgmt_responder;

    localparam int HALF = 8;  // sclk half period in clk_in cycles (sclk = clk/16)

    logic       clk_in = 1'b0;
    logic       n_reset = 1'b0;
    logic       spi_sclk = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_n_ss = 1'b1;
    logic       spi_miso;
    logic [1:0] io_mode;
    logic       status_grn, status_red, cmd_valid;
    logic [7:0] cmd_byte;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_cmd_q[$];
    logic [7:0] rx_buf[3];

    io_spi_mgmt_responder dut (
        .clk_in      (clk_in),
        .n_reset     (n_reset),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_n_ss    (spi_n_ss),
        .spi_miso    (spi_miso),
        .io_mode     (io_mode),
        .status_grn  (status_grn),
        .status_red  (status_red),
        .cmd_valid   (cmd_valid),
        .cmd_byte    (cmd_byte),
        .dbg_state_o (dbg_state)
    );

    always #5 clk_in = ~clk_in;

    // cmd_valid monitor: sampled on the rising edge, away from the DUT's falling edge
    always @(posedge clk_in) begin
        if (cmd_valid) begin
            logic [7:0] e;
            pulse_cnt++;
            checks++;
            if (exp_cmd_q.size() == 0) begin
                errors++;
                $display("FAIL cmd_valid_unexpected: got cmd_byte=%02h, required no strobe", cmd_byte);
            end else begin
                e = exp_cmd_q.pop_front();
                if (cmd_byte !== e) begin
                    errors++;
                    $display("FAIL cmd_byte_at_strobe: got %02h, required %02h", cmd_byte, e);
                end
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk_in);
    endtask

    task automatic spi_bit(input logic b, output logic m);
        spi_mosi = b;
        wait_clks(HALF);
        spi_sclk = 1'b1;
        m = spi_miso;
        wait_clks(HALF);
        spi_sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic m;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], m);
            rx[i] = m;
        end
    endtask

    task automatic frame_begin();
        spi_n_ss = 1'b0;
        wait_clks(HALF);
    endtask

    task automatic frame_end();
        wait_clks(HALF);
        spi_n_ss = 1'b1;
        wait_clks(12);
    endtask

    task automatic do_frame(input int n, input logic [7:0] t0, input logic [7:0] t1, input logic [7:0] t2);
        logic [7:0] r;
        logic [7:0] tv[3];
        tv[0] = t0; tv[1] = t1; tv[2] = t2;
        frame_begin();
        for (int i = 0; i < n; i++) begin
            spi_byte(tv[i], r);
            rx_buf[i] = r;
        end
        frame_end();
    endtask

    task automatic apply_reset();
        n_reset = 1'b0;
        wait_clks(3);
    endtask

    task automatic test_reset();
        spi_n_ss = 1'b1;
        apply_reset();
        checks++;
        if ({io_mode, status_grn, status_red, spi_miso, cmd_valid, cmd_byte, dbg_state} !== {2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0}) begin
            errors++;
            $display("FAIL reset_values: got mode=%b grn=%b red=%b miso=%b cv=%b cb=%02h st=%0d, required mode=10 grn=0 red=1 miso=0 cv=0 cb=00 st=0",
                     io_mode, status_grn, status_red, spi_miso, cmd_valid, cmd_byte, dbg_state);
        end
        n_reset = 1'b1;
        wait_clks(4);
    endtask

    task automatic test_get_mode();
        int p0 = pulse_cnt;
        logic [7:0] e;
        exp_q.push_back(8'hA2); exp_q.push_back(8'h02);
        exp_cmd_q.push_back(8'h01);
        // MSB of status must appear within 3 clocks of select
        checks++;
        if (spi_miso !== 1'b0) begin
            errors++; $display("FAIL miso_idle: got %b, required 0", spi_miso);
        end
        spi_n_ss = 1'b0;
        wait_clks(3);
        checks++;
        if (spi_miso !== 1'b1) begin
            errors++; $display("FAIL status_msb_latency: got %b, required 1", spi_miso);
        end
        spi_n_ss = 1'b1;
        wait_clks(12);
        do_frame(2, 8'h01, 8'h00, 8'h00);
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (rx_buf[i] !== e) begin
                errors++; $display("FAIL get_mode_miso[%0d]: got %02h, required %02h", i, rx_buf[i], e);
            end
        end
        checks++;
        if (io_mode !== 2'b10 || cmd_byte !== 8'h01 || pulse_cnt != p0 + 1 || spi_miso !== 1'b0) begin
            errors++; $display("FAIL get_mode_outputs: got mode=%b cb=%02h pulses=%0d miso=%b, required mode=10 cb=01 pulses=1 miso=0",
                               io_mode, cmd_byte, pulse_cnt - p0, spi_miso);
        end
    endtask

    task automatic test_set_in();
        logic [7:0] r0, r1, e;
        logic m;
        exp_q.push_back(8'hA2); exp_q.push_back(8'h5A);
        exp_cmd_q.push_back(8'h02);
        frame_begin();
        spi_byte(8'h02, r0);
        for (int i = 7; i >= 1; i--) begin
            spi_bit(1'b0, m);
            r1[i] = m;
        end
        checks++;
        if (io_mode !== 2'b10) begin
            errors++; $display("FAIL set_in_early: got %b after 7 data bits, required 10", io_mode);
        end
        spi_bit(1'b0, m);
        r1[0] = m;
        frame_end();
        e = exp_q.pop_front();
        checks++;
        if (r0 !== e) begin errors++; $display("FAIL set_in_status: got %02h, required %02h", r0, e); end
        e = exp_q.pop_front();
        checks++;
        if (r1 !== e) begin errors++; $display("FAIL set_in_resp: got %02h, required %02h", r1, e); end
        checks++;
        if (io_mode !== 2'b01) begin errors++; $display("FAIL set_in_mode: got %b, required 01", io_mode); end
    endtask

    task automatic test_led_and_abort();
        logic [7:0] d, e, r;
        logic m;
        int p0;
        for (int k = 0; k < 3; k++) begin
            d = 8'($urandom_range(0, 3));
            exp_q.push_back(8'hA1); exp_q.push_back(8'h5A);
            exp_cmd_q.push_back(8'h04);
            do_frame(2, 8'h04, d, 8'h00);
            for (int i = 0; i < 2; i++) begin
                e = exp_q.pop_front();
                checks++;
                if (rx_buf[i] !== e) begin
                    errors++; $display("FAIL led_rand_miso[%0d]: got %02h, required %02h", i, rx_buf[i], e);
                end
            end
            checks++;
            if ({status_red, status_grn} !== d[1:0]) begin
                errors++; $display("FAIL led_rand: got red,grn=%b%b, required %b", status_red, status_grn, d[1:0]);
            end
        end
        exp_cmd_q.push_back(8'h04);
        do_frame(2, 8'h04, 8'h01, 8'h00);
        checks++;
        if (status_grn !== 1'b1 || status_red !== 1'b0) begin
            errors++; $display("FAIL led_set: got grn=%b red=%b, required grn=1 red=0", status_grn, status_red);
        end
        p0 = pulse_cnt;
        frame_begin();
        spi_byte(8'h04, r);
        for (int i = 7; i >= 4; i--) spi_bit(1'b0, m);
        frame_end();
        checks++;
        if (status_grn !== 1'b1 || status_red !== 1'b0 || pulse_cnt != p0 || cmd_byte !== 8'h04 || io_mode !== 2'b01) begin
            errors++; $display("FAIL abort_unchanged: got grn=%b red=%b pulses=%0d cb=%02h mode=%b, required grn=1 red=0 pulses=0 cb=04 mode=01",
                               status_grn, status_red, pulse_cnt - p0, cmd_byte, io_mode);
        end
    endtask

    task automatic test_fault();
        logic [7:0] e;
        exp_q.push_back(8'hA1); exp_q.push_back(8'h5A);
        exp_cmd_q.push_back(8'h0F);
        do_frame(2, 8'h0F, 8'h00, 8'h00);
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front(); checks++;
            if (rx_buf[i] !== e) begin errors++; $display("FAIL fault_miso[%0d]: got %02h, required %02h", i, rx_buf[i], e); end
        end
        checks++;
        if (io_mode !== 2'b11 || status_grn !== 1'b0 || status_red !== 1'b1) begin
            errors++; $display("FAIL fault_enter: got mode=%b grn=%b red=%b, required mode=11 grn=0 red=1", io_mode, status_grn, status_red);
        end
        exp_q.push_back(8'hA3); exp_q.push_back(8'hEE);
        exp_cmd_q.push_back(8'h03);
        do_frame(2, 8'h03, 8'h00, 8'h00);
        exp_q.push_back(8'hA3); exp_q.push_back(8'hEE);
        exp_cmd_q.push_back(8'h02);
        do_frame(2, 8'h02, 8'h00, 8'h00);
        // the second frame's bytes overwrite rx_buf; check it against the tail of the queue
        void'(exp_q.pop_front()); void'(exp_q.pop_front());
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front(); checks++;
            if (rx_buf[i] !== e) begin errors++; $display("FAIL fault_nak[%0d]: got %02h, required %02h", i, rx_buf[i], e); end
        end
        checks++;
        if (io_mode !== 2'b11) begin errors++; $display("FAIL fault_sticky: got %b, required 11", io_mode); end
        apply_reset();
        n_reset = 1'b1;
        wait_clks(4);
        checks++;
        if (io_mode !== 2'b10 || status_red !== 1'b1 || status_grn !== 1'b0) begin
            errors++; $display("FAIL fault_reset: got mode=%b grn=%b red=%b, required mode=10 grn=0 red=1", io_mode, status_grn, status_red);
        end
    endtask

    task automatic test_unknown_tail();
        logic [7:0] e;
        int p0 = pulse_cnt;
        exp_q.push_back(8'hA2); exp_q.push_back(8'hEE); exp_q.push_back(8'h00);
        exp_cmd_q.push_back(8'h77);
        do_frame(3, 8'h77, 8'h00, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front(); checks++;
            if (rx_buf[i] !== e) begin errors++; $display("FAIL unknown_miso[%0d]: got %02h, required %02h", i, rx_buf[i], e); end
        end
        checks++;
        if (pulse_cnt != p0 + 1 || cmd_byte !== 8'h77) begin
            errors++; $display("FAIL unknown_strobe: got pulses=%0d cb=%02h, required pulses=1 cb=77", pulse_cnt - p0, cmd_byte);
        end
    endtask

    task automatic test_nop();
        logic [7:0] e;
        int p0 = pulse_cnt;
        exp_q.push_back(8'hA2); exp_q.push_back(8'h00);
        exp_cmd_q.push_back(8'h00);
        do_frame(2, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front(); checks++;
            if (rx_buf[i] !== e) begin errors++; $display("FAIL nop_miso[%0d]: got %02h, required %02h", i, rx_buf[i], e); end
        end
        checks++;
        if (pulse_cnt != p0 + 1 || cmd_byte !== 8'h00) begin
            errors++; $display("FAIL nop_strobe: got pulses=%0d cb=%02h, required pulses=1 cb=00", pulse_cnt - p0, cmd_byte);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] e;
        logic m;
        int p0;
        exp_cmd_q.push_back(8'h04);
        do_frame(2, 8'h04, 8'h01, 8'h00);
        exp_cmd_q.push_back(8'h02);
        do_frame(2, 8'h02, 8'h00, 8'h00);
        frame_begin();
        for (int i = 7; i >= 4; i--) spi_bit(1'b0, m);
        apply_reset();
        checks++;
        if ({io_mode, status_grn, status_red, spi_miso, cmd_valid, cmd_byte, dbg_state} !== {2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0}) begin
            errors++; $display("FAIL midframe_reset: got mode=%b grn=%b red=%b miso=%b cv=%b cb=%02h st=%0d, required mode=10 grn=0 red=1 miso=0 cv=0 cb=00 st=0",
                               io_mode, status_grn, status_red, spi_miso, cmd_valid, cmd_byte, dbg_state);
        end
        n_reset = 1'b1;
        p0 = pulse_cnt;
        for (int i = 3; i >= 0; i--) spi_bit(1'b1, m);
        for (int i = 7; i >= 0; i--) spi_bit(1'b0, m);
        checks++;
        if (pulse_cnt != p0 || dbg_state !== 2'd0 || spi_miso !== 1'b0) begin
            errors++; $display("FAIL midframe_discard: got pulses=%0d st=%0d miso=%b, required pulses=0 st=0 miso=0", pulse_cnt - p0, dbg_state, spi_miso);
        end
        frame_end();
        exp_q.push_back(8'hA2); exp_q.push_back(8'h02);
        exp_cmd_q.push_back(8'h01);
        do_frame(2, 8'h01, 8'h00, 8'h00);
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front(); checks++;
            if (rx_buf[i] !== e) begin errors++; $display("FAIL after_reset_miso[%0d]: got %02h, required %02h", i, rx_buf[i], e); end
        end
    endtask

    initial begin
        test_reset();
        test_get_mode();
        test_set_in();
        test_led_and_abort();
        test_fault();
        test_unknown_tail();
        test_nop();
        test_reset_mid_frame();
        wait_clks(4);
        checks++;
        if (exp_cmd_q.size() != 0) begin
            errors++; $display("FAIL cmd_strobes_missing: got %0d outstanding, required 0", exp_cmd_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
